fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage feeding decode: produces the 32-bit instruction, its PC and a valid flag on the interface decode consumes.
- Requests 64-bit aligned words from the instruction memory port, with one request outstanding at most.
- Splits each word into two instructions and buffers them in a small queue.
- Honours decode stall and branch redirect; responses to requests made before a redirect are dropped.

Parameters:
- RESET_PC, 64'h0, first fetch address after reset (4-byte aligned).
- QDEPTH, 4, instruction queue entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- f_stall  in  1  decode cannot accept; the head entry is held.
- f_redirect  in  1  branch taken; flush and refetch.
- f_redirect_pc  in  64  redirect target; bits [1:0] ignored.
- of_mem_req  out  1  memory request valid.
- of_mem_addr  out  64  request address, bits [2:0]=0.
- f_mem_gnt  in  1  request accepted this cycle.
- f_mem_rvalid  in  1  response data valid.
- f_mem_rdata  in  64  response; [31:0] holds addr+0, [63:32] holds addr+4.
- of_instrux  out  32  queue head instruction (0 when empty).
- of_pc  out  64  queue head PC (0 when empty).
- of_is_inst_valid  out  1  queue non-empty.

Behaviour:
- Reset (async):
  - queue empty; fetch_pc=RESET_PC; state=S_REQ.
  - of_mem_req=0, of_mem_addr=0, of_instrux=0, of_pc=0, of_is_inst_valid=0.
- Decode output: head entry is presented combinationally. Pop occurs when of_is_inst_valid && !f_stall && !f_redirect.
- States:
  - S_REQ
    - of_mem_req = (free entries >= 2) && !f_redirect.
    - of_mem_addr = {fetch_pc[63:3],3'b0}.
    - req && gnt: go to S_WAIT and latch the request PC.
    - When free < 2, req stays low and the state stays S_REQ.
  - S_WAIT, on rvalid:
    - If the latched PC has bit2=0, enqueue rdata[31:0] at pc, then rdata[63:32] at pc+4.
    - If bit2=1, enqueue only rdata[63:32] at pc.
    - fetch_pc becomes the next aligned 8-byte address; go to S_REQ.
  - S_KILL: wait for rvalid, discard the data, go to S_REQ.
- Redirect (highest priority, any state):
  - Queue flushed in the same cycle; pop and enqueue suppressed.
  - fetch_pc={f_redirect_pc[63:2],2'b0}.
  - Next state by current state and event:
    - S_REQ without gnt: S_REQ.
    - S_REQ with gnt in the same cycle: S_KILL (the granted request is stale).
    - S_WAIT without rvalid: S_KILL.
    - S_WAIT with rvalid in the same cycle: data discarded, S_REQ.
    - S_KILL: stays S_KILL with the new PC.
- Latency:
  - Reset release: req asserted in the first cycle after release.
  - gnt edge to rvalid: minimum 1 cycle.
  - rvalid edge: instruction visible at the decode output the next cycle.
  - Redirect: new request asserted the cycle after redirect (S_REQ path).
- Queue behaviour:
  - Enqueue of 1 or 2 entries and pop allowed in the same cycle.
  - Pointers wrap modulo QDEPTH.
  - Count never exceeds QDEPTH, guaranteed by the free>=2 gating.
  - Overflow or underflow is a design error; flag it with an assertion.
- f_stall does not block fetching; requests continue while the queue has space.
- PC arithmetic is 64-bit modulo 2^64; wrap at the top is silent.

Decomposition:
- Shared package fetch_pkg holds:
  - fetch_state_t enum {S_REQ, S_WAIT, S_KILL};
  - INST_W=32, MEM_W=64;
  - queue entry struct {pc[63:0], instrux[31:0]}.
- Sub-module fetch_queue is a synchronous FIFO with flush.
  - Inputs: push0/push1 for up to two entries, pop, flush.
  - Outputs: head, empty, free count.
- fetch_unit holds the FSM, PC logic and split logic.

Test Plan:
- Reset RESET_PC=0x1000, memory with 1-cycle latency, no stall -> req addr 0x1000, then 0x1008; decode sees pc 0x1000, 0x1004, 0x1008 on consecutive valid cycles with correct words.
- Redirect to 0x2004 while in S_WAIT -> old response discarded; next req addr 0x2000; only 0x2004 (upper word) is enqueued, followed by 0x2008.
- Hold f_stall=1 for 10 cycles -> queue fills to QDEPTH=4, req goes low, of_pc is held at the head; release stall -> entries pop in order and fetch resumes.
- Redirect in the same cycle as rvalid -> data discarded, queue empty the next cycle, req to the target the next cycle.
- Redirect in the same cycle as req&&gnt -> S_KILL; the stale rvalid is dropped; new req follows.
- Assert reset mid-S_WAIT with a full queue -> outputs 0 immediately (async); after release req addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction-fetch stage.
package fetch_pkg;

   localparam int INST_W = 32;
   localparam int MEM_W  = 64;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_KILL = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [63:0]       pc;
      logic [INST_W-1:0] instrux;
   } q_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction queue: up to two pushes and one pop per cycle, synchronous flush.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int QDEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push0,
   input  q_entry_t                 i_data0,
   input  logic                     i_push1,
   input  q_entry_t                 i_data1,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output q_entry_t                 o_head,
   output logic                     o_empty,
   output logic [$clog2(QDEPTH):0]  o_free
);

   localparam int PW = $clog2(QDEPTH);

   q_entry_t        r_mem [QDEPTH];
   logic [PW-1:0]   r_rd;
   logic [PW-1:0]   r_wr;
   logic [PW:0]     r_cnt;
   logic [PW-1:0]   w_wr1;
   logic [1:0]      w_npush;

   assign w_wr1   = r_wr + PW'(1);
   assign w_npush = {1'b0, i_push0} + {1'b0, i_push1};

   // Entry storage; push1 always lands in the slot after push0.
   always_ff @(posedge clk) begin
      if (i_push0) r_mem[r_wr]  <= i_data0;
      if (i_push1) r_mem[w_wr1] <= i_data1;
   end

   // Pointers and occupancy; flush empties the queue in one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         r_wr  <= r_wr + PW'(w_npush);
         r_rd  <= r_rd + PW'(i_pop);
         r_cnt <= r_cnt + (PW+1)'(w_npush) - (PW+1)'(i_pop);
      end
   end

   // Head is zero when empty so decode sees clean outputs.
   always_comb begin
      o_head  = '0;
      o_empty = (r_cnt == '0);
      o_free  = (PW+1)'(QDEPTH) - r_cnt;
      if (!o_empty) o_head = r_mem[r_rd];
   end

   a_no_underflow: assert property (@(posedge clk) disable iff (reset)
      i_flush || !(i_pop && (r_cnt == '0)));
   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      i_flush || ((int'(r_cnt) + int'(w_npush) - int'(i_pop)) <= QDEPTH));
   a_push_order: assert property (@(posedge clk) disable iff (reset)
      !i_push1 || i_push0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding 64-bit memory request, split into
// two instructions, queued for decode; redirect flushes and kills stale data.
//
// state  | meaning
// S_REQ  | request next aligned word when the queue has room for two entries
// S_WAIT | request granted, waiting for its response
// S_KILL | outstanding response is stale; drop it when it arrives
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          QDEPTH   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              f_stall,
   input  logic              f_redirect,
   input  logic [63:0]       f_redirect_pc,
   output logic              of_mem_req,
   output logic [63:0]       of_mem_addr,
   input  logic              f_mem_gnt,
   input  logic              f_mem_rvalid,
   input  logic [MEM_W-1:0]  f_mem_rdata,
   output logic [INST_W-1:0] of_instrux,
   output logic [63:0]       of_pc,
   output logic              of_is_inst_valid
);

   localparam int PW = $clog2(QDEPTH);

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;
   logic [63:0]  r_fetch_pc;
   logic [63:0]  r_req_pc;
   logic         w_req;
   logic         w_push0;
   logic         w_push1;
   logic         w_pop;
   q_entry_t     w_d0;
   q_entry_t     w_d1;
   q_entry_t     w_head;
   logic         w_empty;
   logic [PW:0]  w_free;
   logic         w_unused_ok;

   assign w_unused_ok = &{1'b0, f_redirect_pc[1:0]};

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_REQ;
      else       r_state <= w_state_nxt;
   end

   // Next state; redirect overrides normal progress.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_REQ: begin
            if (f_redirect)               w_state_nxt = f_mem_gnt ? S_KILL : S_REQ;
            else if (w_req && f_mem_gnt)  w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (f_mem_rvalid)             w_state_nxt = S_REQ;
            else if (f_redirect)          w_state_nxt = S_KILL;
         end
         S_KILL: begin
            // a response arriving with a redirect still retires the stale request
            if (f_mem_rvalid)             w_state_nxt = S_REQ;
         end
         default:                         w_state_nxt = S_REQ;
      endcase
   end

   // Outputs: memory request, queue pushes and pop.
   always_comb begin
      w_req       = (r_state == S_REQ) && (w_free >= (PW+1)'(2)) && !f_redirect;
      of_mem_req  = w_req && !reset;
      of_mem_addr = reset ? 64'h0 : {r_fetch_pc[63:3], 3'b000};
      w_push0     = (r_state == S_WAIT) && f_mem_rvalid && !f_redirect;
      w_push1     = w_push0 && !r_req_pc[2];
      w_pop       = of_is_inst_valid && !f_stall && !f_redirect;
      w_d0        = '{pc: r_req_pc,
                      instrux: r_req_pc[2] ? f_mem_rdata[63:32] : f_mem_rdata[31:0]};
      w_d1        = '{pc: r_req_pc + 64'd4, instrux: f_mem_rdata[63:32]};
   end

   // Fetch PC and the PC of the outstanding request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= '0;
      end else begin
         if (f_redirect)
            r_fetch_pc <= {f_redirect_pc[63:2], 2'b00};
         else if ((r_state == S_WAIT) && f_mem_rvalid)
            r_fetch_pc <= {r_req_pc[63:3], 3'b000} + 64'd8;
         if (w_req && f_mem_gnt)
            r_req_pc <= r_fetch_pc;
      end
   end

   fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
      .clk     (clk),
      .reset   (reset),
      .i_push0 (w_push0),
      .i_data0 (w_d0),
      .i_push1 (w_push1),
      .i_data1 (w_d1),
      .i_pop   (w_pop),
      .i_flush (f_redirect),
      .o_head  (w_head),
      .o_empty (w_empty),
      .o_free  (w_free)
   );

   assign of_is_inst_valid = !w_empty;
   assign of_pc            = w_head.pc;
   assign of_instrux       = w_head.instrux;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; the bench plays the instruction memory.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        f_stall;
   logic        f_redirect;
   logic [63:0] f_redirect_pc;
   logic        of_mem_req;
   logic [63:0] of_mem_addr;
   logic        f_mem_gnt;
   logic        f_mem_rvalid;
   logic [63:0] f_mem_rdata;
   logic [31:0] of_instrux;
   logic [63:0] of_pc;
   logic        of_is_inst_valid;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(64'h1000), .QDEPTH(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .f_stall          (f_stall),
      .f_redirect       (f_redirect),
      .f_redirect_pc    (f_redirect_pc),
      .of_mem_req       (of_mem_req),
      .of_mem_addr      (of_mem_addr),
      .f_mem_gnt        (f_mem_gnt),
      .f_mem_rvalid     (f_mem_rvalid),
      .f_mem_rdata      (f_mem_rdata),
      .of_instrux       (of_instrux),
      .of_pc            (of_pc),
      .of_is_inst_valid (of_is_inst_valid)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [63:0] pc,
                          input logic [31:0] ins);
      check({tag, ".valid"}, {63'h0, of_is_inst_valid}, {63'h0, v});
      check({tag, ".pc"}, of_pc, pc);
      check({tag, ".instrux"}, {32'h0, of_instrux}, {32'h0, ins});
   endtask

   task automatic chk_req(input string tag, input logic req, input logic [63:0] addr);
      check({tag, ".req"}, {63'h0, of_mem_req}, {63'h0, req});
      if (req) check({tag, ".addr"}, of_mem_addr, addr);
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: observed timeout expected end of sequence");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; f_stall = 1'b0; f_redirect = 1'b0; f_redirect_pc = '0;
      f_mem_gnt = 1'b0; f_mem_rvalid = 1'b0; f_mem_rdata = '0;
      cyc(); cyc(); #1;
      chk_req("rst", 1'b0, 64'h0);
      check("rst.addr", of_mem_addr, 64'h0);
      chk_out("rst", 1'b0, 64'h0, 32'h0);

      // sequential fetch from RESET_PC
      cyc(); reset = 1'b0; #1;
      chk_req("rel", 1'b1, 64'h1000);
      f_mem_gnt = 1'b1;
      cyc(); f_mem_gnt = 1'b0; f_mem_rvalid = 1'b1; f_mem_rdata = 64'hC0DE1004_C0DE1000; #1;
      chk_req("wait1", 1'b0, 64'h0);
      chk_out("wait1", 1'b0, 64'h0, 32'h0);
      cyc(); f_mem_rvalid = 1'b0; #1;
      chk_out("seq0", 1'b1, 64'h1000, 32'hC0DE1000);
      chk_req("seq0", 1'b1, 64'h1008);
      f_mem_gnt = 1'b1;
      cyc(); f_mem_gnt = 1'b0; f_mem_rvalid = 1'b1; f_mem_rdata = 64'hC0DE100C_C0DE1008; #1;
      chk_out("seq1", 1'b1, 64'h1004, 32'hC0DE1004);
      cyc(); f_mem_rvalid = 1'b0; #1;
      chk_out("seq2", 1'b1, 64'h1008, 32'hC0DE1008);
      chk_req("seq2", 1'b1, 64'h1010);
      f_mem_gnt = 1'b1;

      // redirect while waiting; low pc bits must be ignored
      cyc(); f_mem_gnt = 1'b0; f_redirect = 1'b1; f_redirect_pc = 64'h2007; #1;
      chk_req("redw", 1'b0, 64'h0);
      chk_out("redw", 1'b1, 64'h100C, 32'hC0DE100C);
      cyc(); f_redirect = 1'b0; f_mem_rvalid = 1'b1; f_mem_rdata = 64'hDEADBEEF_DEADBEEF; #1;
      chk_out("flush", 1'b0, 64'h0, 32'h0);
      chk_req("kill", 1'b0, 64'h0);
      cyc(); f_mem_rvalid = 1'b0; #1;
      chk_out("stale", 1'b0, 64'h0, 32'h0);
      chk_req("redreq", 1'b1, 64'h2000);
      f_mem_gnt = 1'b1;
      cyc(); f_mem_gnt = 1'b0; f_mem_rvalid = 1'b1; f_mem_rdata = 64'hC0DE2004_C0DE2000;
      cyc(); f_mem_rvalid = 1'b0; #1;
      chk_out("upper", 1'b1, 64'h2004, 32'hC0DE2004);
      chk_req("upper", 1'b1, 64'h2008);
      f_mem_gnt = 1'b1;
      cyc(); f_mem_gnt = 1'b0; f_mem_rvalid = 1'b1; f_mem_rdata = 64'hC0DE200C_C0DE2008; #1;
      chk_out("single", 1'b0, 64'h0, 32'h0);
      cyc(); f_mem_rvalid = 1'b0; #1;
      chk_out("r2008", 1'b1, 64'h2008, 32'hC0DE2008);
      chk_req("r2008", 1'b1, 64'h2010);

      // stall: queue fills, request drops, head held
      f_stall = 1'b1; f_mem_gnt = 1'b1;
      cyc(); f_mem_gnt = 1'b0; f_mem_rvalid = 1'b1; f_mem_rdata = 64'hC0DE2014_C0DE2010; #1;
      chk_out("stall0", 1'b1, 64'h2008, 32'hC0DE2008);
      cyc(); f_mem_rvalid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk_req("full", 1'b0, 64'h0);
         check("hold.pc", of_pc, 64'h2008);
         cyc();
      end
      f_stall = 1'b0; #1;
      chk_out("rel0", 1'b1, 64'h2008, 32'hC0DE2008);
      chk_req("rel0", 1'b0, 64'h0);
      cyc(); #1;
      chk_out("rel1", 1'b1, 64'h200C, 32'hC0DE200C);
      chk_req("rel1", 1'b0, 64'h0);
      cyc(); #1;
      chk_out("rel2", 1'b1, 64'h2010, 32'hC0DE2010);
      chk_req("rel2", 1'b1, 64'h2018);
      cyc(); #1;
      chk_out("rel3", 1'b1, 64'h2014, 32'hC0DE2014);
      cyc(); #1;
      chk_out("drain", 1'b0, 64'h0, 32'h0);
      chk_req("resume", 1'b1, 64'h2018);

      // redirect together with rvalid
      f_mem_gnt = 1'b1;
      cyc(); f_mem_gnt = 1'b0; f_mem_rvalid = 1'b1; f_mem_rdata = 64'hC0DE201C_C0DE2018;
      f_redirect = 1'b1; f_redirect_pc = 64'h3000;
      cyc(); f_mem_rvalid = 1'b0; f_redirect = 1'b0; #1;
      chk_out("rvred", 1'b0, 64'h0, 32'h0);
      chk_req("rvred", 1'b1, 64'h3000);

      // redirect together with grant
      f_mem_gnt = 1'b1; f_redirect = 1'b1; f_redirect_pc = 64'h4008; #1;
      chk_req("gntred", 1'b0, 64'h0);
      cyc(); f_mem_gnt = 1'b0; f_redirect = 1'b0; #1;
      chk_req("kill1", 1'b0, 64'h0);
      cyc(); #1;
      chk_req("kill2", 1'b0, 64'h0);
      f_mem_rvalid = 1'b1; f_mem_rdata = 64'hDEADBEEF_DEADBEEF;
      cyc(); f_mem_rvalid = 1'b0; #1;
      chk_out("kdrop", 1'b0, 64'h0, 32'h0);
      chk_req("kreq", 1'b1, 64'h4008);
      f_mem_gnt = 1'b1;
      cyc(); f_mem_gnt = 1'b0; f_mem_rvalid = 1'b1; f_mem_rdata = 64'hC0DE400C_C0DE4008;
      cyc(); f_mem_rvalid = 1'b0; #1;
      chk_out("r4008", 1'b1, 64'h4008, 32'hC0DE4008);
      chk_req("r4008", 1'b1, 64'h4010);

      // async reset while waiting with entries queued
      f_stall = 1'b1; f_mem_gnt = 1'b1;
      cyc(); f_mem_gnt = 1'b0; #1;
      chk_req("w4010", 1'b0, 64'h0);
      chk_out("w4010", 1'b1, 64'h4008, 32'hC0DE4008);
      #2; reset = 1'b1; #1;
      chk_req("arst", 1'b0, 64'h0);
      check("arst.addr", of_mem_addr, 64'h0);
      chk_out("arst", 1'b0, 64'h0, 32'h0);
      cyc(); reset = 1'b0; f_stall = 1'b0; #1;
      chk_req("rel2nd", 1'b1, 64'h1000);
      chk_out("rel2nd", 1'b0, 64'h0, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
